imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the RV32/RV64 decode path. It decodes every base-ISA immediate format (I, S, B, U, J) from a 32-bit instruction and sign-extends the result to XLEN. It also reports the format and carries a sideband tag. The block sits between instruction-register write and operand selection, and uses a valid/ready handshake with a one-entry skid buffer so back-pressure from execute never loses an instruction.

---
 rtl/imm_gen_pipe.sv | 177 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe - pipelined RV32/RV64 immediate generator.
//
// Decodes the I/S/B/U/J immediate of a 32-bit instruction, sign-extends it
// to XLEN, reports the format code and carries a sideband tag. A valid/ready
// handshake with an output register (OR) and a one-entry skid register (SK)
// absorbs back-pressure without losing instructions.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   in_valid_i     instruction presented
//   in_ready_o     block accepts this cycle (registered, = !SK.valid)
//   in_instr_i     raw 32-bit instruction
//   in_tag_i       sideband tag, carried unchanged
//   out_valid_o    decoded result presented
//   out_ready_i    consumer accepts the result
//   out_imm_o      sign-extended immediate (XLEN bits)
//   out_fmt_o      0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
//   out_tag_o      tag of the presented result
//   out_illegal_o  unrecognised opcode (only with IMM_GEN_ILLEGAL_EN)
//
// Optional feature macro: IMM_GEN_ILLEGAL_EN adds the out_illegal_o flag.

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_instr_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_imm_o,
  output logic [2:0]       out_fmt_o,
`ifdef IMM_GEN_ILLEGAL_EN
  output logic             out_illegal_o,
`endif
  output logic [TAG_W-1:0] out_tag_o
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam bit RV64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
`ifdef IMM_GEN_ILLEGAL_EN
    logic             ill;
`endif
  } entry_t;

  logic [6:0]  opc;
  logic [2:0]  dec_fmt;
  logic [31:0] imm32;
  entry_t      dec;

  assign opc = in_instr_i[6:0];

  always_comb begin
    dec_fmt = FMT_NONE;
    unique case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR,
      OPC_MISC_MEM, OPC_SYSTEM:       dec_fmt = FMT_I;
      OPC_STORE:                      dec_fmt = FMT_S;
      OPC_BRANCH:                     dec_fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:             dec_fmt = FMT_U;
      OPC_JAL:                        dec_fmt = FMT_J;
      OPC_OP_IMM32:                   dec_fmt = RV64 ? FMT_I : FMT_NONE;
      default:                        dec_fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    imm32 = '0;
    unique case (dec_fmt)
      FMT_I: imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
      FMT_S: imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
      FMT_B: imm32 = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                      in_instr_i[30:25], in_instr_i[11:8], 1'b0};
      FMT_U: imm32 = {in_instr_i[31:12], 12'b0};
      FMT_J: imm32 = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                      in_instr_i[20], in_instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    dec.imm = XLEN'($signed(imm32));
    dec.fmt = dec_fmt;
    dec.tag = in_tag_i;
`ifdef IMM_GEN_ILLEGAL_EN
    // OP (and OP-32 on RV64) legitimately decode to NONE; every other NONE
    // is an unknown opcode. The 7-bit compare already rejects instr[1:0]!=11.
    dec.ill = (dec_fmt == FMT_NONE) && (opc != OPC_OP) &&
              !(RV64 && (opc == OPC_OP32));
`endif
  end

  entry_t or_q, or_d, sk_q, sk_d;
  logic   or_valid_q, or_valid_d;
  logic   sk_valid_q, sk_valid_d;
  logic   in_ready_q;
  logic   in_fire, out_fire;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = or_valid_q & out_ready_i;

  always_comb begin
    or_d       = or_q;
    or_valid_d = or_valid_q;
    sk_d       = sk_q;
    sk_valid_d = sk_valid_q;
    if (out_fire && sk_valid_q) begin
      // in_ready is low whenever SK holds data, so no input can fire here.
      or_d       = sk_q;
      sk_valid_d = 1'b0;
    end else if (in_fire && (!or_valid_q || out_fire)) begin
      or_d       = dec;
      or_valid_d = 1'b1;
    end else if (in_fire) begin
      sk_d       = dec;
      sk_valid_d = 1'b1;
    end else if (out_fire) begin
      or_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      or_q       <= '0;
      sk_q       <= '0;
      or_valid_q <= 1'b0;
      sk_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      or_q       <= or_d;
      sk_q       <= sk_d;
      or_valid_q <= or_valid_d;
      sk_valid_q <= sk_valid_d;
      in_ready_q <= !sk_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = or_valid_q;
  assign out_imm_o   = or_q.imm;
  assign out_fmt_o   = or_q.fmt;
  assign out_tag_o   = or_q.tag;
`ifdef IMM_GEN_ILLEGAL_EN
  assign out_illegal_o = or_q.ill;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic [4:0]  out_tag32;
  logic        in_ready64, out_valid64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [4:0]  out_tag64;
`ifdef IMM_GEN_ILLEGAL_EN
  logic        out_ill32, out_ill64;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready32),
    .in_instr_i(in_instr), .in_tag_i(in_tag),
    .out_valid_o(out_valid32), .out_ready_i(out_ready),
    .out_imm_o(out_imm32), .out_fmt_o(out_fmt32),
`ifdef IMM_GEN_ILLEGAL_EN
    .out_illegal_o(out_ill32),
`endif
    .out_tag_o(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready64),
    .in_instr_i(in_instr), .in_tag_i(in_tag),
    .out_valid_o(out_valid64), .out_ready_i(out_ready),
    .out_imm_o(out_imm64), .out_fmt_o(out_fmt64),
`ifdef IMM_GEN_ILLEGAL_EN
    .out_illegal_o(out_ill64),
`endif
    .out_tag_o(out_tag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [4:0] tag);
    in_valid = v;
    in_instr = instr;
    in_tag   = tag;
  endtask

  // One instruction in with out_ready=1, result checked the next cycle.
  task automatic dec_vec(input string name, input logic [31:0] instr, input logic [4:0] tag,
                         input logic [31:0] e_imm32, input logic [2:0] e_fmt32,
                         input logic [63:0] e_imm64, input logic [2:0] e_fmt64,
                         input logic e_ill32, input logic e_ill64);
    drive(1'b1, instr, tag);
    tick();
    chk({name, "_valid"}, {63'd0, out_valid32}, 64'd1);
    chk({name, "_imm32"}, {32'd0, out_imm32}, {32'd0, e_imm32});
    chk({name, "_fmt32"}, {61'd0, out_fmt32}, {61'd0, e_fmt32});
    chk({name, "_tag32"}, {59'd0, out_tag32}, {59'd0, tag});
    chk({name, "_imm64"}, out_imm64, e_imm64);
    chk({name, "_fmt64"}, {61'd0, out_fmt64}, {61'd0, e_fmt64});
`ifdef IMM_GEN_ILLEGAL_EN
    chk({name, "_ill32"}, {63'd0, out_ill32}, {63'd0, e_ill32});
    chk({name, "_ill64"}, {63'd0, out_ill64}, {63'd0, e_ill64});
`else
    if (e_ill32 || e_ill64) begin end
`endif
  endtask

  initial begin
    logic [31:0] instr;
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0);
    tick();
    tick();
    rst = 1'b0;

    chk("rst_out_valid", {63'd0, out_valid32}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready32},  64'd1);
    chk("rst_imm",       {32'd0, out_imm32},   64'd0);
    chk("rst_fmt",       {61'd0, out_fmt32},   64'd0);
    chk("rst_tag",       {59'd0, out_tag32},   64'd0);

    // Directed decode vectors
    out_ready = 1'b1;
    dec_vec("addi",  32'hFFF00093, 5'd3,  32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 1'b0);
    dec_vec("sw_m4", 32'hFE112E23, 5'd4,  32'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0, 1'b0);
    dec_vec("sw_p4", 32'h00112223, 5'd5,  32'h00000004, 3'd2, 64'h0000000000000004, 3'd2, 1'b0, 1'b0);
    dec_vec("beq",   32'hFE000CE3, 5'd6,  32'hFFFFFFF8, 3'd3, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0, 1'b0);
    dec_vec("lui",   32'h123452B7, 5'd7,  32'h12345000, 3'd4, 64'h0000000012345000, 3'd4, 1'b0, 1'b0);
    dec_vec("auipc", 32'hFFFFF017, 5'd8,  32'hFFFFF000, 3'd4, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0, 1'b0);
    dec_vec("jal",   32'h001000EF, 5'd9,  32'h00000800, 3'd5, 64'h0000000000000800, 3'd5, 1'b0, 1'b0);
    dec_vec("bad7f", 32'h0000007F, 5'd10, 32'h00000000, 3'd0, 64'h0,                3'd0, 1'b1, 1'b1);
    dec_vec("addiw", 32'hFFF0001B, 5'd11, 32'h00000000, 3'd0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b1, 1'b0);
    dec_vec("op",    32'h00000033, 5'd12, 32'h00000000, 3'd0, 64'h0,                3'd0, 1'b0, 1'b0);
    dec_vec("op32",  32'h0000003B, 5'd13, 32'h00000000, 3'd0, 64'h0,                3'd0, 1'b1, 1'b0);
    dec_vec("lo00",  32'h00000010, 5'd14, 32'h00000000, 3'd0, 64'h0,                3'd0, 1'b1, 1'b1);

    drive(1'b0, 32'h0, 5'd0);
    tick();
    chk("idle_valid", {63'd0, out_valid32}, 64'd0);

    // Back-pressure: four instructions, imm = 0x21..0x24, tags 16..19
    out_ready = 1'b0;
    drive(1'b1, 32'h02100013, 5'd16);
    chk("bp_rdy0", {63'd0, in_ready32}, 64'd1);
    tick();
    drive(1'b1, 32'h02200013, 5'd17);
    chk("bp_rdy1", {63'd0, in_ready32}, 64'd1);
    tick();
    drive(1'b1, 32'h02300013, 5'd18);
    chk("bp_rdy2", {63'd0, in_ready32}, 64'd0);
    chk("bp_hold_tag_a", {59'd0, out_tag32}, 64'd16);
    tick();
    chk("bp_rdy3", {63'd0, in_ready32}, 64'd0);
    chk("bp_hold_valid", {63'd0, out_valid32}, 64'd1);
    chk("bp_hold_tag_b", {59'd0, out_tag32}, 64'd16);
    chk("bp_hold_imm", {32'd0, out_imm32}, 64'h21);
    out_ready = 1'b1;
    tick();
    chk("bp_out1_tag", {59'd0, out_tag32}, 64'd17);
    chk("bp_out1_imm", {32'd0, out_imm32}, 64'h22);
    chk("bp_rdy_back", {63'd0, in_ready32}, 64'd1);
    tick();
    chk("bp_out2_tag", {59'd0, out_tag32}, 64'd18);
    chk("bp_out2_imm", {32'd0, out_imm32}, 64'h23);
    drive(1'b1, 32'h02400013, 5'd19);
    tick();
    chk("bp_out3_tag", {59'd0, out_tag32}, 64'd19);
    chk("bp_out3_imm", {32'd0, out_imm32}, 64'h24);
    drive(1'b0, 32'h0, 5'd0);
    tick();
    chk("bp_drained", {63'd0, out_valid32}, 64'd0);

    // Full throughput: 16 back-to-back with out_ready=1
    for (int i = 0; i < 16; i++) begin
      instr = {12'(i + 100), 20'h00013};
      drive(1'b1, instr, 5'(i));
      tick();
      chk("tp_valid", {63'd0, out_valid32}, 64'd1);
      chk("tp_tag",   {59'd0, out_tag32},   64'(i));
      chk("tp_imm",   {32'd0, out_imm32},   64'(i + 100));
    end
    drive(1'b0, 32'h0, 5'd0);
    tick();
    chk("tp_end_valid", {63'd0, out_valid32}, 64'd0);

    // Reset with both entries full
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 5'd21);
    tick();
    drive(1'b1, 32'h123452B7, 5'd22);
    tick();
    chk("full_rdy", {63'd0, in_ready32}, 64'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 5'd0);
    chk("rst2_valid", {63'd0, out_valid32}, 64'd0);
    chk("rst2_ready", {63'd0, in_ready32},  64'd1);
    chk("rst2_imm",   {32'd0, out_imm32},   64'd0);
    chk("rst2_fmt",   {61'd0, out_fmt32},   64'd0);
    chk("rst2_tag",   {59'd0, out_tag32},   64'd0);
    chk("rst2_imm64", out_imm64,            64'd0);
    tick();
    chk("rst2_after", {63'd0, out_valid32}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
